// File: rtl/display_pkg.sv
// Shared constants, state encoding and BCD helpers for the multiplexed
// 5-digit display scan controller.
package display_pkg;

   localparam int unsigned NUM_DIGITS = 5;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned BCD_W      = 20;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned IDX_W      = 3;
   localparam logic [3:0]  BLANK      = 4'hF;

   typedef enum logic {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } conv_state_t;

   // One nibble per decimal digit, digit 0 = units.
   typedef logic [NUM_DIGITS-1:0][3:0] bcd_t;

   // Double-dabble correction: add 3 to every nibble that is 5 or more.
   function automatic bcd_t bcd_adjust(input bcd_t acc);
      bcd_t res;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         res[i] = (acc[i] >= 4'd5) ? acc[i] + 4'd3 : acc[i];
      end
      return res;
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter: one shift-and-add-3 step per clock,
// DATA_W steps per conversion, start/busy/done handshake.
module bin2bcd_serial
   import display_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] din,
   output logic              busy,
   output logic              done_c,
   output bcd_t              bcd_c
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   conv_state_t       state;
   logic [DATA_W-1:0] shreg;
   bcd_t              acc;
   logic [CNT_W-1:0]  bitcnt;
   bcd_t              acc_adj;

   assign busy = (state == CONVERT);

   // Next accumulator value; on the last step this is the finished result.
   always_comb begin
      acc_adj = bcd_adjust(acc);
      bcd_c   = BCD_W'({acc_adj, shreg[DATA_W-1]});
      done_c  = (state == CONVERT) && (bitcnt == LAST_STEP);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         shreg  <= '0;
         acc    <= '0;
         bitcnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg  <= din;
                  acc    <= '0;
                  bitcnt <= '0;
                  state  <= CONVERT;
               end
            end
            CONVERT: begin
               shreg  <= {shreg[DATA_W-2:0], 1'b0};
               acc    <= bcd_c;
               bitcnt <= bitcnt + CNT_W'(1);
               if (bitcnt == LAST_STEP) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Converts a 16-bit value to decimal and time-multiplexes the five digits
// onto a shared 7-segment decoder with optional leading-zero blanking.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int unsigned SCAN_DIV      = 50000,
   parameter bit          ZERO_SUPPRESS = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     valor,
   input  logic                  load,
   output logic                  busy,
   output logic [3:0]            digito,
   output logic [NUM_DIGITS-1:0] anodo
);

   localparam int unsigned       PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(NUM_DIGITS - 1);

   logic             conv_done_c;
   bcd_t             conv_bcd_c;
   bcd_t             disp;
   logic [PRE_W-1:0] prescale;
   logic [IDX_W-1:0] idx;
   logic [BCD_W-1:0] upper;
   logic             blank;

   bin2bcd_serial u_conv (
      .clock  (clock),
      .reset  (reset),
      .start  (load),
      .din    (valor),
      .busy   (busy),
      .done_c (conv_done_c),
      .bcd_c  (conv_bcd_c)
   );

   // Display register only changes on the commit edge, never mid-conversion.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         disp <= '0;
      end else if (conv_done_c) begin
         disp <= conv_bcd_c;
      end
   end

   // Free-running digit scan, independent of the converter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prescale <= '0;
         idx      <= '0;
      end else if (prescale == PRE_MAX) begin
         prescale <= '0;
         idx      <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
      end else begin
         prescale <= prescale + PRE_W'(1);
      end
   end

   // Blank a digit when it and every more significant digit are zero.
   always_comb begin
      upper  = BCD_W'(disp) >> {idx, 2'b00};
      blank  = ZERO_SUPPRESS && (idx != '0) && (upper == '0);
      digito = blank ? BLANK : disp[idx];
      anodo  = ~(NUM_DIGITS'(1) << idx);
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench: two instances (zero suppression on/off, different scan
// dividers) compared every cycle against a decimal-arithmetic reference model.
module tb_display_scan_ctrl;

   localparam int DIV_A = 4;
   localparam int DIV_B = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load  = 1'b0;
   logic [15:0] valor = 16'd0;

   logic        busy_a, busy_b;
   logic [3:0]  dig_a, dig_b;
   logic [4:0]  an_a, an_b;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int cyc       = 0;
   int busy_left = 0;
   int pend      = 0;
   int shown     = 0;

   always #5 clock = ~clock;

   display_scan_ctrl #(.SCAN_DIV(DIV_A), .ZERO_SUPPRESS(1'b1)) dut_a (
      .clock (clock), .reset (reset), .valor (valor), .load (load),
      .busy  (busy_a), .digito (dig_a), .anodo (an_a)
   );

   display_scan_ctrl #(.SCAN_DIV(DIV_B), .ZERO_SUPPRESS(1'b0)) dut_b (
      .clock (clock), .reset (reset), .valor (valor), .load (load),
      .busy  (busy_b), .digito (dig_b), .anodo (an_b)
   );

   function automatic logic [3:0] exp_digit(input int v, input int pos, input bit zs);
      int p;
      p = 1;
      for (int k = 0; k < pos; k++) p = p * 10;
      if (zs && pos > 0 && v < p) return 4'hF;
      return 4'((v / p) % 10);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cyc=%0d t=%0t)", tag, obs, exp, cyc, $time);
      end
   endtask

   task automatic check_all(input string tag);
      int ia, ib;
      logic [4:0] ea, eb;
      ia = (cyc / DIV_A) % 5;
      ib = (cyc / DIV_B) % 5;
      ea = ~(5'(1) << ia);
      eb = ~(5'(1) << ib);
      chk({tag, "/busy_a"},  32'(busy_a), 32'(busy_left > 0));
      chk({tag, "/busy_b"},  32'(busy_b), 32'(busy_left > 0));
      chk({tag, "/anodo_a"}, 32'(an_a),   32'(ea));
      chk({tag, "/anodo_b"}, 32'(an_b),   32'(eb));
      chk({tag, "/digit_a"}, 32'(dig_a),  32'(exp_digit(shown, ia, 1'b1)));
      chk({tag, "/digit_b"}, 32'(dig_b),  32'(exp_digit(shown, ib, 1'b0)));
   endtask

   // One clock: update the model from the inputs seen at the edge, check at negedge.
   task automatic tick(input string tag);
      @(posedge clock);
      if (!reset) begin
         cyc++;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) shown = pend;
         end else if (load) begin
            pend      = int'(valor);
            busy_left = 16;
         end
      end
      @(negedge clock);
      check_all(tag);
   endtask

   task automatic run(input int n, input string tag);
      repeat (n) tick(tag);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset(input string tag);
      reset = 1'b1;
      #2;
      cyc       = 0;
      busy_left = 0;
      shown     = 0;
      check_all(tag);
      reset = 1'b0;
   endtask

   task automatic load_value(input logic [15:0] v, input string tag);
      valor = v;
      load  = 1'b1;
      tick(tag);
      load  = 1'b0;
   endtask

   initial begin
      // Reset state and blank scan
      #2;
      check_all("reset");
      reset = 1'b0;
      run(25, "idle_scan");

      // 1234
      load_value(16'd1234, "ld1234");
      run(16 + 25, "conv1234");

      // Maximum value
      load_value(16'd65535, "ld65535");
      run(16 + 25, "conv65535");

      // Zero
      load_value(16'd0, "ld0");
      run(16 + 25, "conv0");

      // Load while busy is dropped
      load_value(16'd42, "ld42");
      run(4, "busy42");
      load_value(16'd999, "ld999_ignored");
      run(12 + 25, "conv42");

      // Reset mid-conversion aborts with no commit
      load_value(16'd777, "ld777");
      run(7, "busy777");
      pulse_reset("reset_mid");
      run(40, "after_abort");

      // Load held high: back-to-back conversions
      load  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         valor = 16'($urandom);
         tick("load_held");
      end
      load = 1'b0;
      run(20, "load_held_tail");

      // Randomized traffic with a mix of magnitudes and occasional resets
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0:       valor = 16'($urandom_range(0, 9));
            1:       valor = 16'($urandom_range(0, 999));
            2:       valor = 16'($urandom_range(1000, 65535));
            default: valor = 16'($urandom);
         endcase
         load = ($urandom_range(0, 5) == 0);
         tick("random");
         if ($urandom_range(0, 149) == 0) pulse_reset("random_reset");
      end
      load = 1'b0;
      run(40, "final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles each digit stays selected; legal range 2..2^20.
REQ-002 Parameter ZERO_SUPPRESS, default 1: 1 = blank leading zeros, 0 = show all digits.
REQ-003 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port valor, input, 16: unsigned binary value to display; sampled only on an accepted load.
REQ-006 Port load, input, 1: conversion request; accepted only when busy=0.
REQ-007 Port busy, output, 1: high while a conversion is in progress.
REQ-008 Port digito, output, 4: BCD nibble driven to the shared 7-segment decoder; 4'hF = blank.
REQ-009 Port anodo, output, 5: digit select, one-hot active-low; bit 0 = units digit.

Function
REQ-010 The block SHALL use a two-state FSM: IDLE and CONVERT.
REQ-011 In IDLE with load=1, the block SHALL capture valor into a 16-bit shift register, clear a 20-bit BCD accumulator and bit counter, and enter CONVERT on the same edge.
REQ-012 In IDLE with load=0, the FSM SHALL stay in IDLE.
REQ-013 In CONVERT, each cycle SHALL perform one shift-and-add-3 step: add 3 to any accumulator nibble >=5, then shift left by one with the binary MSB entering.
REQ-014 After exactly 16 CONVERT cycles, the block SHALL copy the accumulator into the 5-nibble display register and return to IDLE on that same edge.
REQ-015 busy SHALL equal (state==CONVERT): high for exactly 16 cycles after the accepting edge, and low on the edge that commits the display register.
REQ-016 A load received while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-017 The display register SHALL keep its previous value for the whole conversion, so the display never shows partial results.
REQ-018 A free-running prescaler SHALL count 0..SCAN_DIV-1 and wrap; on terminal count the digit index SHALL advance 0,1,2,3,4 and wrap to 0.
REQ-019 Scanning SHALL be independent of FSM state and SHALL NOT pause during conversion.
REQ-020 anodo SHALL equal the bitwise inverse of (1 << index); exactly one bit SHALL be low at any time.
REQ-021 digito SHALL equal display nibble[index].
REQ-022 Exception to REQ-021: when ZERO_SUPPRESS=1, index>0, and nibble[index] plus all higher nibbles are 0, digito SHALL be 4'hF.
REQ-023 Digit 0 SHALL never be blanked.
REQ-024 digito and anodo SHALL be combinational decodes of registered index and display register only.

Reset
REQ-025 While reset=1, the block SHALL force the following immediately, asynchronously to clock: state=IDLE, busy=0, shift register=0, accumulator=0, bit counter=0, display register=0, prescaler=0, index=0, anodo=5'b11110, digito=4'h0.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion with no commit.
REQ-027 The first load accepted after reset release SHALL behave per REQ-011.

Structure
REQ-028 Shared package display_pkg SHALL hold: NUM_DIGITS=5, DATA_W=16, BCD_W=20, BLANK=4'hF, and the IDLE/CONVERT state encoding.
REQ-029 The conversion datapath (REQ-011 to REQ-014) SHALL be the sub-module bin2bcd_serial, with start/busy/done handshake.
REQ-030 display_scan_ctrl SHALL own the scan logic and the display register.
REQ-031 The existing 7-segment decoder SHALL be instantiated outside this block and fed by digito.

Verification
REQ-032 Reset test: reset pulse -> anodo=11110, digito=0, busy=0; over one scan period, digits 1..4 show 4'hF (ZERO_SUPPRESS=1).
REQ-033 Basic conversion: load with valor=1234 -> busy high exactly 16 cycles; then scan yields 4,3,2,1,F on anodo bits 0..4.
REQ-034 Maximum value: valor=65535 -> scan yields 5,3,5,5,6.
REQ-035 Zero with ZERO_SUPPRESS=0: valor=0 -> scan yields 0,0,0,0,0.
REQ-036 Load while busy and hold: load 42, then load 999 on the 5th busy cycle -> display shows 2,4,F,F,F; display unchanged mid-conversion; index wraps 4->0 after 5*SCAN_DIV cycles with SCAN_DIV=4.
REQ-037 Reset mid-conversion: reset on the 8th busy cycle of load 777 -> busy=0, display shows 0,F,F,F,F, and no commit occurs afterwards.
